// File: rtl/cipher_pkg.sv
// Shared state encoding, ASCII constants and mod-26 letter helpers
// for the Vigenere engine.
package cipher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [7:0] CH_UA   = 8'h41;
   localparam logic [7:0] CH_UZ   = 8'h5A;
   localparam logic [7:0] CH_LA   = 8'h61;
   localparam logic [7:0] CH_LZ   = 8'h7A;
   localparam logic [5:0] ALPHA_N = 6'd26;

   function automatic logic is_upper(input logic [7:0] c);
      return (c >= CH_UA) && (c <= CH_UZ);
   endfunction

   function automatic logic is_lower(input logic [7:0] c);
      return (c >= CH_LA) && (c <= CH_LZ);
   endfunction

   // Case-insensitive alphabet position; non-letters map to 0.
   function automatic logic [4:0] letter_index(input logic [7:0] c);
      logic [7:0] d;
      if (is_upper(c)) begin
         d = c - CH_UA;
      end else if (is_lower(c)) begin
         d = c - CH_LA;
      end else begin
         d = 8'd0;
      end
      return d[4:0];
   endfunction

   // Rotate a 0..25 letter position by sh with one conditional correction.
   function automatic logic [4:0] rotate(input logic [4:0] idx, input logic [4:0] sh,
                                         input logic dec);
      logic [5:0] t;
      if (dec) begin
         t = {1'b0, idx} - {1'b0, sh};
         if (idx < sh) begin
            t = t + ALPHA_N;
         end
      end else begin
         t = {1'b0, idx} + {1'b0, sh};
         if (t >= ALPHA_N) begin
            t = t - ALPHA_N;
         end
      end
      return t[4:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; output reads as zero while empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push_s, do_pop_s;

   assign full_o    = (count_q == (AW + 1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: unread slots are never observed.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/vigenere_engine.sv
// Streaming Vigenere cipher: loads a key, then encrypts/decrypts letters
// into an output FIFO, passing non-letters through.
module vigenere_engine
   import cipher_pkg::*;
#(
   parameter int KEY_LEN    = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CHAR_W     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_key,
   input  logic                       key_done,
   input  logic                       decrypt,
   input  logic                       in_valid,
   input  logic [CHAR_W-1:0]          in_char,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [CHAR_W-1:0]          out_char,
   input  logic                       out_ready,
   output logic [1:0]                 state,
   output logic [$clog2(KEY_LEN)-1:0] key_idx
);

   localparam int KW = $clog2(KEY_LEN);
   localparam int CW = KW + 1;
   localparam int FW = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q, state_d;
   logic [CHAR_W-1:0] key_q [KEY_LEN];
   logic [CW-1:0]     key_len_cnt_q, key_len_cnt_d, key_len_q, key_len_d;
   logic [KW-1:0]     key_idx_q, key_idx_d;
   logic              handshake_s, key_wr_s, key_default_s, push_s;
   logic              fifo_full_s, fifo_empty_s;
   logic [FW-1:0]     fifo_count_unused;
   logic [7:0]        in_c8_s, key_c8_s, out_c8_s;
   logic              in_hi_zero_s, key_hi_zero_s, in_letter_s;
   logic [CHAR_W-1:0] key_char_s, cipher_s;
   logic [4:0]        shift_s, new_idx_s;

   assign state       = state_q;
   assign key_idx     = key_idx_q;
   assign out_valid   = !fifo_empty_s;
   assign handshake_s = in_valid && in_ready;
   assign push_s      = (state_q == ST_RUN) && handshake_s;
   assign key_wr_s    = (state_q == ST_LOAD) && handshake_s && !load_key &&
                        (key_len_cnt_q < CW'(KEY_LEN));

   // Characters above 8 bits wide are never letters.
   assign key_char_s    = key_q[key_idx_q];
   assign in_c8_s       = in_char[7:0];
   assign key_c8_s      = key_char_s[7:0];
   assign in_hi_zero_s  = ((in_char >> 8) == '0);
   assign key_hi_zero_s = ((key_char_s >> 8) == '0);
   assign in_letter_s   = in_hi_zero_s && (is_upper(in_c8_s) || is_lower(in_c8_s));
   assign shift_s       = key_hi_zero_s ? letter_index(key_c8_s) : 5'd0;
   assign new_idx_s     = rotate(letter_index(in_c8_s), shift_s, decrypt);
   assign out_c8_s      = (is_upper(in_c8_s) ? CH_UA : CH_LA) + {3'b000, new_idx_s};
   assign cipher_s      = in_letter_s ? CHAR_W'(out_c8_s) : in_char;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_key) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (load_key) begin
               state_d = ST_LOAD;
            end else if (key_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            in_ready = !fifo_full_s;
            if (load_key) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      key_len_cnt_d = key_len_cnt_q;
      key_len_d     = key_len_q;
      key_idx_d     = key_idx_q;
      key_default_s = 1'b0;
      if (load_key) begin
         key_len_cnt_d = '0;
         key_idx_d     = '0;
      end else if (state_q == ST_LOAD) begin
         if (key_wr_s) begin
            key_len_cnt_d = key_len_cnt_q + CW'(1);
         end
         if (key_done) begin
            key_default_s = (key_len_cnt_d == '0);
            key_len_d     = key_default_s ? CW'(1) : key_len_cnt_d;
         end
      end else if (push_s && in_letter_s) begin
         if (CW'(key_idx_q) == key_len_q - CW'(1)) begin
            key_idx_d = '0;
         end else begin
            key_idx_d = key_idx_q + KW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         key_len_cnt_q <= '0;
         key_len_q     <= CW'(1);
         key_idx_q     <= '0;
      end else begin
         state_q       <= state_d;
         key_len_cnt_q <= key_len_cnt_d;
         key_len_q     <= key_len_d;
         key_idx_q     <= key_idx_d;
      end
   end

   // An empty key entry behaves as the single key letter 'A'.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < KEY_LEN; i++) begin
            key_q[i] <= CHAR_W'(CH_UA);
         end
      end else if (key_wr_s) begin
         key_q[key_len_cnt_q[KW-1:0]] <= in_char;
      end else if (key_default_s) begin
         key_q[0] <= CHAR_W'(CH_UA);
      end
   end

   sync_fifo #(
      .WIDTH (CHAR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .data_i  (cipher_s),
      .pop_i   (out_ready),
      .data_o  (out_char),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_unused)
   );

endmodule

// File: tb/tb_vigenere_engine.sv
// Self-checking bench for vigenere_engine: directed cases plus randomized
// traffic against a queue-based reference model.
module tb_vigenere_engine;

   localparam int KL = 8;
   localparam int FD = 4;

   logic       clk, reset, load_key, key_done, decrypt, in_valid, in_ready;
   logic       out_valid, out_ready;
   logic [7:0] in_char, out_char;
   logic [1:0] state;
   logic [2:0] key_idx;

   vigenere_engine #(.KEY_LEN(KL), .FIFO_DEPTH(FD), .CHAR_W(8)) dut (
      .clk(clk), .reset(reset), .load_key(load_key), .key_done(key_done),
      .decrypt(decrypt), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
      .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
      .state(state), .key_idx(key_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          mstate   = 0;
   int          mkidx    = 0;
   logic [7:0]  mkey[$];
   logic [7:0]  mq[$];
   logic [63:0] cap = 64'd0;
   logic [63:0] ks  = 64'd0;
   logic        last_ready;
   logic        acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [7:0] model_enc(input logic [7:0] c, input logic [7:0] k,
                                            input logic dec);
      int s, b;
      if (k >= 8'd65 && k <= 8'd90)       s = int'(k) - 65;
      else if (k >= 8'd97 && k <= 8'd122) s = int'(k) - 97;
      else                                s = 0;
      if (c >= 8'd65 && c <= 8'd90)       b = 65;
      else if (c >= 8'd97 && c <= 8'd122) b = 97;
      else return c;
      if (dec) s = 26 - s;
      return 8'(b + ((int'(c) - b + s) % 26));
   endfunction

   function automatic logic m_is_letter(input logic [7:0] c);
      return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
   endfunction

   function automatic logic [7:0] rnd_char();
      case ($urandom_range(0, 3))
         0:       return 8'(65 + $urandom_range(0, 25));
         1:       return 8'(97 + $urandom_range(0, 25));
         2:       return 8'(48 + $urandom_range(0, 9));
         default: return 8'(32 + $urandom_range(0, 15));
      endcase
   endfunction

   // One clock cycle: drive at negedge, sample 1 ns later, then advance the model.
   task automatic cycle(input logic lk, input logic kd, input logic dec, input logic iv,
                        input logic [7:0] ch, input logic ord, output logic accepted);
      logic exp_ready;
      @(negedge clk);
      load_key = lk; key_done = kd; decrypt = dec;
      in_valid = iv; in_char = ch; out_ready = ord;
      #1;
      exp_ready = (mstate == 1) ? 1'b1 : (mstate == 2) ? (mq.size() < FD) : 1'b0;
      last_ready = in_ready;
      check("state", 64'(state), 64'(mstate));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("key_idx", 64'(key_idx), 64'(mkidx));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (ord && mq.size() > 0) begin
         check("out_char", 64'(out_char), 64'(mq[0]));
         cap = {cap[55:0], out_char};
         void'(mq.pop_front());
      end
      accepted = iv && exp_ready;
      if (accepted) begin
         if (mstate == 1) begin
            if (!lk && mkey.size() < KL) mkey.push_back(ch);
         end else begin
            mq.push_back(model_enc(ch, mkey[mkidx], dec));
            ks = {ks[59:0], 4'(key_idx)};
            if (m_is_letter(ch)) mkidx = (mkidx + 1) % mkey.size();
         end
      end
      if (lk) begin
         mstate = 1; mkey.delete(); mkidx = 0;
      end else if (mstate == 1 && kd) begin
         mstate = 2;
         if (mkey.size() == 0) mkey.push_back(8'h41);
      end
   endtask

   task automatic idle(input int n);
      logic a;
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, a);
   endtask

   task automatic load_key_str(input string k);
      logic a;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, a);
      for (int i = 0; i < k.len(); i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, k[i], 1'b1, a);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, a);
   endtask

   task automatic send_str(input string s, input logic dec, input logic ord);
      logic a;
      for (int i = 0; i < s.len(); i++) begin
         a = 1'b0;
         for (int t = 0; t < 20 && !a; t++) cycle(1'b0, 1'b0, dec, 1'b1, s[i], ord, a);
         if (!a) check("accept_timeout", 64'd0, 64'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load_key = 1'b0; key_done = 1'b0; decrypt = 1'b0;
      in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
      #2;
      check("rst_state", 64'(state), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_char", 64'(out_char), 64'd0);
      check("rst_key_idx", 64'(key_idx), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      load_key_str("KEY");
      cap = 64'd0; ks = 64'd0;
      send_str("HELLO", 1'b0, 1'b1); idle(6);
      check("hello_enc", cap, "RIJVS");
      check("hello_kidx", ks, 64'h01201);

      load_key_str("KEY");
      cap = 64'd0;
      send_str("RIJVS", 1'b1, 1'b1); idle(6);
      check("rijvs_dec", cap, "HELLO");

      load_key_str("KEY");
      cap = 64'd0; ks = 64'd0;
      send_str("A B", 1'b0, 1'b1); idle(6);
      check("space_enc", cap, "K F");
      check("space_kidx", ks, 64'h011);

      load_key_str("B");
      cap = 64'd0;
      send_str("Zz", 1'b0, 1'b1); idle(6);
      check("wrap_enc", cap, "Aa");
      cap = 64'd0;
      send_str("a", 1'b1, 1'b1); idle(6);
      check("wrap_dec", cap, "z");

      load_key_str("");
      cap = 64'd0;
      send_str("Q", 1'b0, 1'b1); idle(6);
      check("empty_key", cap, "Q");

      // Back-pressure: fill the buffer, then free one slot for the fifth char.
      load_key_str("KEY");
      cap = 64'd0;
      send_str("ABCD", 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "E", 1'b0, acc);
      check("ready_full", 64'(last_ready), 64'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "E", 1'b1, acc);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "E", 1'b0, acc);
      check("fifth_accept", 64'(last_ready), 64'd1);
      idle(6);
      check("fifo_order", cap, "KFANI");

      load_key_str("ABCDEFGHI");
      cap = 64'd0; ks = 64'd0;
      send_str("AAAAAAAAA", 1'b0, 1'b1); idle(6);
      check("long_key_out", cap, "BCDEFGHA");
      check("long_key_kidx", ks, 64'h012345670);

      // Asynchronous reset with three characters buffered.
      load_key_str("KEY");
      send_str("XYZ", 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, acc);
      reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_state", 64'(state), 64'd0);
      check("arst_out_char", 64'(out_char), 64'd0);
      mq.delete(); mstate = 0; mkidx = 0; mkey.delete();
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "Q", 1'b1, acc);
      check("post_rst_ready", 64'(last_ready), 64'd0);

      for (int r = 0; r < 6; r++) begin
         int klen;
         klen = int'($urandom_range(0, 10));
         cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, acc);
         for (int j = 0; j < klen; j++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, rnd_char(), 1'($urandom_range(0, 1)), acc);
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, acc);
         for (int j = 0; j < 80; j++)
            cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 10),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
                  rnd_char(), 1'($urandom_range(0, 9) < 6), acc);
         idle(6);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
